// File: rtl/seq_frame_decoder.sv
// ----------------------------------------------------------------------------
// seq_frame_decoder
//
// Buffers sequencer frames in a small FIFO and, on each step pulse, applies
// the oldest buffered frame to the DAC/PDM output registers. Each DAC channel
// can be ramped down to zero at RAMP_STEP per cycle instead of jumping to a
// new value, which avoids output glitches when a channel is switched off.
//
// Ports
//   clk            : clock, rising edge
//   aresetn        : synchronous active-low reset
//   seq_data       : frame payload (W bits)
//   seq_valid      : frame push request
//   seq_ready      : buffer can accept a frame (low while in reset or full)
//   step           : pulse, apply next buffered frame
//   clear_status   : pulse, clear sticky underrun
//   dac_value      : signed 16-bit value per DAC channel
//   pdm_value      : 11-bit value per PDM channel
//   enable_dac     : per-DAC enable from the active frame
//   resync_dac     : per-DAC resync bit from the active frame
//   ramp_done      : per-DAC, high once a ramp-down has reached zero
//   enable_pdm     : per-PDM enable from the active frame
//   underrun       : sticky, a step arrived with the buffer empty
//   frames_applied : number of frames applied (wrapping)
// ----------------------------------------------------------------------------
module seq_frame_decoder #(
    parameter int N_DAC     = 2,
    parameter int N_PDM     = 4,
    parameter int DEPTH     = 4,
    parameter int RAMP_STEP = 16,
    localparam int W        = 16*(N_DAC+N_PDM)+32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [W-1:0]           seq_data,
    input  logic                   seq_valid,
    output logic                   seq_ready,
    input  logic                   step,
    input  logic                   clear_status,
    output logic [16*N_DAC-1:0]    dac_value,
    output logic [11*N_PDM-1:0]    pdm_value,
    output logic [N_DAC-1:0]       enable_dac,
    output logic [N_DAC-1:0]       resync_dac,
    output logic [N_DAC-1:0]       ramp_done,
    output logic [N_PDM-1:0]       enable_pdm,
    output logic                   underrun,
    output logic [31:0]            frames_applied
);

    localparam int AW = $clog2(DEPTH);
    localparam int B  = 16*N_DAC;   // base of the PDM fields
    localparam int FB = W-32;       // base of the flag word

    typedef enum logic [1:0] {ST_RUN, ST_RAMP, ST_ZERO} dac_st_t;

    // 14-bit two's complement field to 16-bit signed
    function automatic logic signed [15:0] sext14(input logic [13:0] f);
        return {{2{f[13]}}, f};
    endfunction

    // One ramp step toward zero; clamps at zero so the sign never flips.
    function automatic logic signed [15:0] ramp_toward_zero(input logic signed [15:0] v);
        logic signed [16:0] v17;
        logic signed [16:0] s17;
        v17 = {v[15], v};
        s17 = 17'(RAMP_STEP);
        if (v17 > s17)
            return 16'(v17 - s17);
        else if (v17 < -s17)
            return 16'(v17 + s17);
        else
            return '0;
    endfunction

    // Frame buffer storage (data only, never reset; occupancy lives in r_count)
    logic [W-1:0]              r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_count;

    // Output registers
    logic                      r_underrun;
    logic [31:0]               r_frames;
    logic [N_DAC-1:0]          r_en_dac;
    logic [N_DAC-1:0]          r_resync;
    logic [N_DAC-1:0]          r_done;
    logic [N_PDM-1:0]          r_en_pdm;
    logic [11*N_PDM-1:0]       r_pdm;
    logic signed [15:0]        r_dac [N_DAC];
    dac_st_t                   r_st  [N_DAC];

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_underrun_evt;
    logic [W-1:0]              w_head;
    logic [N_DAC-1:0]          w_ramp_req;
    logic signed [15:0]        w_field   [N_DAC];
    logic signed [15:0]        w_stepped [N_DAC];
    logic                      w_unused_head;

    assign w_full         = (r_count == (AW+1)'(DEPTH));
    assign w_empty        = (r_count == '0);
    // Gated by aresetn so the buffer refuses frames during reset and accepts
    // them from the first cycle after release.
    assign seq_ready      = aresetn && !w_full;
    assign w_push         = seq_valid && seq_ready;
    assign w_pop          = step && !w_empty;
    // A step with an empty buffer never bypasses a same-cycle push.
    assign w_underrun_evt = step && w_empty;

    assign w_head         = r_mem[r_rd_ptr];
    assign w_ramp_req     = w_head[FB+16 +: N_DAC];
    assign w_unused_head  = ^w_head;

    always_comb begin
        for (int d = 0; d < N_DAC; d++) begin
            w_field[d]   = sext14(w_head[16*d +: 14]);
            w_stepped[d] = ramp_toward_zero(r_dac[d]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= seq_data;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_underrun <= 1'b0;
            r_frames   <= '0;
            r_en_dac   <= '0;
            r_resync   <= '0;
            r_done     <= '0;
            r_en_pdm   <= '0;
            r_pdm      <= '0;
            for (int d = 0; d < N_DAC; d++) begin
                r_dac[d] <= '0;
                r_st[d]  <= ST_RUN;
            end
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase

            // A new underrun wins over a same-cycle clear.
            if (w_underrun_evt)
                r_underrun <= 1'b1;
            else if (clear_status)
                r_underrun <= 1'b0;

            if (w_pop) begin
                r_frames <= r_frames + 32'd1;
                r_en_dac <= w_head[FB +: N_DAC];
                r_en_pdm <= w_head[FB+N_DAC +: N_PDM];
                for (int d = 0; d < N_DAC; d++)
                    r_resync[d] <= w_head[16*d+15];
                for (int p = 0; p < N_PDM; p++)
                    r_pdm[11*p +: 11] <= w_head[B+16*p +: 11];
            end

            // Per-channel ramp control. A ramp starts from the value currently
            // on the output, not from the new frame's field.
            for (int d = 0; d < N_DAC; d++) begin
                case (r_st[d])
                    ST_RUN: begin
                        if (w_pop) begin
                            if (w_ramp_req[d]) begin
                                r_dac[d]  <= w_stepped[d];
                                r_st[d]   <= (w_stepped[d] == 16'sd0) ? ST_ZERO : ST_RAMP;
                                r_done[d] <= (w_stepped[d] == 16'sd0);
                            end else begin
                                r_dac[d]  <= w_field[d];
                            end
                        end
                    end
                    ST_RAMP: begin
                        if (w_pop && !w_ramp_req[d]) begin
                            r_dac[d]  <= w_field[d];
                            r_st[d]   <= ST_RUN;
                            r_done[d] <= 1'b0;
                        end else begin
                            r_dac[d] <= w_stepped[d];
                            if (w_stepped[d] == 16'sd0) begin
                                r_st[d]   <= ST_ZERO;
                                r_done[d] <= 1'b1;
                            end
                        end
                    end
                    ST_ZERO: begin
                        if (w_pop && !w_ramp_req[d]) begin
                            r_dac[d]  <= w_field[d];
                            r_st[d]   <= ST_RUN;
                            r_done[d] <= 1'b0;
                        end
                    end
                    default: begin
                        r_dac[d]  <= '0;
                        r_st[d]   <= ST_RUN;
                        r_done[d] <= 1'b0;
                    end
                endcase
            end
        end
    end

    genvar gd;
    generate
        for (gd = 0; gd < N_DAC; gd++) begin : g_dac
            assign dac_value[16*gd +: 16] = r_dac[gd];
        end
    endgenerate

    assign pdm_value      = r_pdm;
    assign enable_dac     = r_en_dac;
    assign resync_dac     = r_resync;
    assign ramp_done      = r_done;
    assign enable_pdm     = r_en_pdm;
    assign underrun       = r_underrun;
    assign frames_applied = r_frames;

endmodule

// File: tb/tb_seq_frame_decoder.sv
// ----------------------------------------------------------------------------
// tb_seq_frame_decoder
//
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based reference model of the frame decoder.
// ----------------------------------------------------------------------------
module tb_seq_frame_decoder;

    localparam int N_DAC     = 2;
    localparam int N_PDM     = 4;
    localparam int DEPTH     = 4;
    localparam int RAMP_STEP = 16;
    localparam int W         = 16*(N_DAC+N_PDM)+32;

    logic                   clk = 1'b0;
    logic                   aresetn;
    logic [W-1:0]           seq_data;
    logic                   seq_valid;
    logic                   seq_ready;
    logic                   step;
    logic                   clear_status;
    logic [16*N_DAC-1:0]    dac_value;
    logic [11*N_PDM-1:0]    pdm_value;
    logic [N_DAC-1:0]       enable_dac;
    logic [N_DAC-1:0]       resync_dac;
    logic [N_DAC-1:0]       ramp_done;
    logic [N_PDM-1:0]       enable_pdm;
    logic                   underrun;
    logic [31:0]            frames_applied;

    always #5 clk = ~clk;

    seq_frame_decoder #(
        .N_DAC(N_DAC), .N_PDM(N_PDM), .DEPTH(DEPTH), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .seq_data(seq_data),
        .seq_valid(seq_valid),
        .seq_ready(seq_ready),
        .step(step),
        .clear_status(clear_status),
        .dac_value(dac_value),
        .pdm_value(pdm_value),
        .enable_dac(enable_dac),
        .resync_dac(resync_dac),
        .ramp_done(ramp_done),
        .enable_pdm(enable_pdm),
        .underrun(underrun),
        .frames_applied(frames_applied)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [W-1:0]  mq[$];
    bit [W-1:0]  mact;
    int          mval  [N_DAC];
    bit          mramp [N_DAC];
    bit          mund;
    bit [31:0]   mcnt;

    function automatic int toward0(input int v);
        if (v > RAMP_STEP)  return v - RAMP_STEP;
        if (v < -RAMP_STEP) return v + RAMP_STEP;
        return 0;
    endfunction

    function automatic int fld(input bit [W-1:0] f, input int d);
        int v;
        v = int'(f[16*d +: 14]);
        if (v >= 8192) v -= 16384;
        return v;
    endfunction

    task automatic model_step();
        bit         do_pop;
        bit         do_push;
        bit [W-1:0] f;
        if (!aresetn) begin
            mq.delete();
            mact = '0;
            mund = 1'b0;
            mcnt = '0;
            for (int d = 0; d < N_DAC; d++) begin
                mval[d]  = 0;
                mramp[d] = 1'b0;
            end
        end else begin
            do_pop  = step && (mq.size() > 0);
            do_push = seq_valid && (mq.size() < DEPTH);
            f = '0;
            if (step && mq.size() == 0) mund = 1'b1;
            else if (clear_status)      mund = 1'b0;
            if (do_pop) begin
                f = mq.pop_front();
                mact = f;
                mcnt = mcnt + 32'd1;
            end
            for (int d = 0; d < N_DAC; d++) begin
                if (do_pop && !f[W-16+d]) begin
                    mramp[d] = 1'b0;
                    mval[d]  = fld(f, d);
                end else begin
                    if (do_pop) mramp[d] = 1'b1;
                    if (mramp[d]) mval[d] = toward0(mval[d]);
                end
            end
            if (do_push) mq.push_back(seq_data);
        end
    endtask

    task automatic compare_all();
        logic [16*N_DAC-1:0] edac;
        logic [11*N_PDM-1:0] epdm;
        logic [N_DAC-1:0]    edone;
        logic [N_DAC-1:0]    eres;
        for (int d = 0; d < N_DAC; d++) begin
            edac[16*d +: 16] = 16'(mval[d]);
            edone[d]         = mramp[d] && (mval[d] == 0);
            eres[d]          = mact[16*d+15];
        end
        for (int p = 0; p < N_PDM; p++)
            epdm[11*p +: 11] = mact[16*N_DAC+16*p +: 11];
        chk("seq_ready",      seq_ready,      aresetn && (mq.size() < DEPTH));
        chk("dac_value",      dac_value,      edac);
        chk("pdm_value",      pdm_value,      epdm);
        chk("enable_dac",     enable_dac,     mact[W-32 +: N_DAC]);
        chk("enable_pdm",     enable_pdm,     mact[W-32+N_DAC +: N_PDM]);
        chk("resync_dac",     resync_dac,     eres);
        chk("ramp_done",      ramp_done,      edone);
        chk("underrun",       underrun,       mund);
        chk("frames_applied", frames_applied, mcnt);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        seq_valid    = 1'b0;
        step         = 1'b0;
        clear_status = 1'b0;
    endtask

    function automatic bit [W-1:0] mkf(input int d0, input int d1, input bit [1:0] rd);
        bit [W-1:0] f;
        f = '0;
        f[13:0]      = 14'(d0);
        f[29:16]     = 14'(d1);
        f[W-32 +: 2] = 2'b11;
        f[W-16 +: 2] = rd;
        return f;
    endfunction

    task automatic push1(input bit [W-1:0] f);
        seq_data  = f;
        seq_valid = 1'b1;
        cyc();
        seq_valid = 1'b0;
    endtask

    task automatic step1();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    bit [W-1:0] tf;

    initial begin
        aresetn = 1'b0;
        seq_data = '0;
        idle();
        repeat (3) cyc();
        chk("rst_ready", seq_ready, 1'b0);
        aresetn = 1'b1;
        cyc();
        chk("ready_after_rst", seq_ready, 1'b1);

        // empty step -> underrun, clear, clear racing a new underrun
        step1();
        chk("und_empty_step", underrun, 1'b1);
        chk("dac_hold_zero", dac_value, 32'h0);
        clear_status = 1'b1; cyc(); clear_status = 1'b0;
        chk("und_cleared", underrun, 1'b0);
        clear_status = 1'b1; step = 1'b1; cyc(); idle();
        chk("und_clr_vs_step", underrun, 1'b1);
        clear_status = 1'b1; cyc(); clear_status = 1'b0;

        // basic decode with sign extension and PDM field
        tf = mkf(14'h1FFF, 14'h2000, 2'b00);
        tf[16*N_DAC+32 +: 11] = 11'h7FF;
        push1(tf);
        step1();
        chk("dac0_1FFF", dac_value[15:0], 16'h1FFF);
        chk("dac1_E000", dac_value[31:16], 16'hE000);
        chk("pdm2_7FF", pdm_value[32:22], 11'h7FF);
        chk("frames_1", frames_applied, 32'd1);

        // push and step together on empty buffer: no bypass
        seq_data = mkf(321, 0, 2'b00); seq_valid = 1'b1; step = 1'b1;
        cyc(); idle();
        chk("nobypass_und", underrun, 1'b1);
        chk("nobypass_dac", dac_value[15:0], 16'h1FFF);
        step1();
        chk("nobypass_pop", dac_value[15:0], 16'd321);
        clear_status = 1'b1; cyc(); clear_status = 1'b0;

        // fill, back-pressure, order
        for (int i = 0; i < 4; i++) push1(mkf(101+i, 0, 2'b00));
        chk("full_ready0", seq_ready, 1'b0);
        seq_data = mkf(105, 0, 2'b00); seq_valid = 1'b1;
        cyc();
        step = 1'b1; cyc(); step = 1'b0;
        chk("ready_after_pop", seq_ready, 1'b1);
        cyc(); seq_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step1();
            chk("fifo_order", dac_value[15:0], 16'(102+i));
        end

        // ramp 1000 -> 0 in 63 cycles, then resume at 500
        push1(mkf(1000, 7, 2'b00));
        step1();
        push1(mkf(14'h123, 9, 2'b01));
        push1(mkf(500, 11, 2'b00));
        step1();
        chk("ramp_first", dac_value[15:0], 16'd984);
        chk("ramp_ch1_run", dac_value[31:16], 16'd9);
        repeat (62) cyc();
        chk("ramp_end_val", dac_value[15:0], 16'd0);
        chk("ramp_end_done", ramp_done[0], 1'b1);
        step1();
        chk("resume_500", dac_value[15:0], 16'd500);
        chk("resume_done0", ramp_done[0], 1'b0);

        // negative ramp with no overshoot
        push1(mkf(-20, 0, 2'b00));
        step1();
        push1(mkf(0, 0, 2'b01));
        step1();
        chk("neg_ramp_m4", dac_value[15:0], 16'hFFFC);
        cyc();
        chk("neg_ramp_zero", dac_value[15:0], 16'h0000);
        chk("neg_ramp_done", ramp_done[0], 1'b1);

        // abort a ramp in progress
        push1(mkf(2000, 0, 2'b00));
        step1();
        push1(mkf(0, 0, 2'b11));
        step1();
        push1(mkf(77, 0, 2'b00));
        cyc();
        step1();
        chk("abort_new", dac_value[15:0], 16'd77);
        chk("abort_done", ramp_done[0], 1'b0);

        // reset mid-ramp with frames buffered
        push1(mkf(3000, 0, 2'b00));
        step1();
        push1(mkf(0, 0, 2'b01));
        step1();
        for (int i = 0; i < 3; i++) push1(mkf(40+i, 0, 2'b00));
        aresetn = 1'b0;
        cyc();
        chk("rst_mid_dac", dac_value, 32'h0);
        chk("rst_mid_ready", seq_ready, 1'b0);
        aresetn = 1'b1;
        cyc();
        chk("rst_rel_ready", seq_ready, 1'b1);
        step1();
        chk("rst_rel_und", underrun, 1'b1);
        chk("rst_rel_frames", frames_applied, 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            seq_valid    = 1'($urandom_range(0, 1));
            step         = ($urandom_range(0, 3) == 0);
            clear_status = ($urandom_range(0, 9) == 0);
            aresetn      = ($urandom_range(0, 299) != 0);
            seq_data     = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                seq_data[13:0]  = 14'($urandom_range(0, 200) - 100);
                seq_data[29:16] = 14'($urandom_range(0, 200) - 100);
            end
            cyc();
        end
        idle();
        aresetn = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
